// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode constants, class-enable bit positions and FIFO entry type.
package rv32i_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int unsigned EN_BRANCH = 0;
    localparam int unsigned EN_JALR   = 1;
    localparam int unsigned EN_JAL    = 2;
    localparam int unsigned EN_LUI    = 3;
    localparam int unsigned EN_AUIPC  = 4;
    localparam int unsigned EN_OP_IMM = 5;
    localparam int unsigned EN_OP     = 6;
    localparam int unsigned EN_COUNT  = 7;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fifo_entry_t;

endpackage

// File: rtl/decode_issue_rv_if.sv
// Fetch-side and ALU-side handshake bundle of the decode/issue stage.
interface decode_issue_rv_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        alu_branch_enable;
    logic        alu_unconditional_jalr_enable;
    logic        alu_unconditional_jal_enable;
    logic        alu_upper_immediate_lui_enable;
    logic        alu_upper_immediate_auipc_enable;
    logic        alu_register_immediate_enable;
    logic        alu_register_register_enable;
    logic        out_illegal;

    modport master (
        output in_valid, in_instruction, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instruction, out_pc, out_rs1, out_rs2,
               alu_branch_enable, alu_unconditional_jalr_enable,
               alu_unconditional_jal_enable, alu_upper_immediate_lui_enable,
               alu_upper_immediate_auipc_enable, alu_register_immediate_enable,
               alu_register_register_enable, out_illegal
    );

    modport slave (
        input  in_valid, in_instruction, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instruction, out_pc, out_rs1, out_rs2,
               alu_branch_enable, alu_unconditional_jalr_enable,
               alu_unconditional_jal_enable, alu_upper_immediate_lui_enable,
               alu_upper_immediate_auipc_enable, alu_register_immediate_enable,
               alu_register_register_enable, out_illegal
    );

endinterface

// File: rtl/decode_class_rv.sv
// Combinational opcode classifier: one-hot class enables or illegal flag.
module decode_class_rv
    import rv32i_pkg::*;
(
    input  logic [6:0]          opcode,
    output logic [EN_COUNT-1:0] enables,
    output logic                illegal
);

    // Map the 7-bit opcode to exactly one class bit, or flag it illegal.
    always_comb begin
        enables = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_BRANCH: enables[EN_BRANCH] = 1'b1;
            OPC_JALR:   enables[EN_JALR]   = 1'b1;
            OPC_JAL:    enables[EN_JAL]    = 1'b1;
            OPC_LUI:    enables[EN_LUI]    = 1'b1;
            OPC_AUIPC:  enables[EN_AUIPC]  = 1'b1;
            OPC_OP_IMM: enables[EN_OP_IMM] = 1'b1;
            OPC_OP:     enables[EN_OP]     = 1'b1;
            default:    illegal            = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_issue_rv.sv
// Decode/issue stage: 2-entry instruction FIFO with head classification.
module decode_issue_rv
    import rv32i_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    decode_issue_rv_if.slave       bus,
    output logic [COUNT_WIDTH-1:0] issue_count
);

    fifo_entry_t            entry_q [2];
    fifo_entry_t            entry_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;
    logic [COUNT_WIDTH-1:0] issue_count_q, issue_count_d;

    logic                   in_ready;
    logic                   out_valid;
    logic                   push;
    logic                   pop;
    fifo_entry_t            head;
    logic [EN_COUNT-1:0]    class_en;
    logic                   class_illegal;

    // Handshake qualifiers; flush and reset block both sides of the FIFO.
    always_comb begin
        in_ready  = (count_q < 2'd2) && !bus.flush && !reset;
        out_valid = (count_q != 2'd0) && !bus.flush && !reset;
        push      = bus.in_valid && in_ready;
        pop       = out_valid && bus.out_ready;
        head      = entry_q[rd_ptr_q];
    end

    decode_class_rv u_class (
        .opcode  (head.instruction[6:0]),
        .enables (class_en),
        .illegal (class_illegal)
    );

    // Next-state for storage, pointers, occupancy and the issue counter.
    always_comb begin
        entry_d       = entry_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        issue_count_d = issue_count_q;
        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                entry_d[wr_ptr_q] = '{instruction: bus.in_instruction, pc: bus.in_pc};
                wr_ptr_d          = !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d      = !rd_ptr_q;
                issue_count_d = issue_count_q + COUNT_WIDTH'(1);
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_q       <= '{default: '0};
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= '0;
            issue_count_q <= '0;
        end else begin
            entry_q       <= entry_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            issue_count_q <= issue_count_d;
        end
    end

    // Head presentation; every field is forced to zero while nothing is valid.
    always_comb begin
        bus.in_ready                         = in_ready;
        bus.out_valid                        = out_valid;
        bus.out_instruction                  = out_valid ? head.instruction : '0;
        bus.out_pc                           = out_valid ? head.pc : '0;
        bus.out_rs1                          = out_valid ? head.instruction[19:15] : '0;
        bus.out_rs2                          = out_valid ? head.instruction[24:20] : '0;
        bus.alu_branch_enable                = out_valid && class_en[EN_BRANCH];
        bus.alu_unconditional_jalr_enable    = out_valid && class_en[EN_JALR];
        bus.alu_unconditional_jal_enable     = out_valid && class_en[EN_JAL];
        bus.alu_upper_immediate_lui_enable   = out_valid && class_en[EN_LUI];
        bus.alu_upper_immediate_auipc_enable = out_valid && class_en[EN_AUIPC];
        bus.alu_register_immediate_enable    = out_valid && class_en[EN_OP_IMM];
        bus.alu_register_register_enable     = out_valid && class_en[EN_OP];
        bus.out_illegal                      = out_valid && class_illegal;
    end

    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_decode_issue_rv.sv
// Scoreboard bench for decode_issue_rv: directed pushes, monitor-side compare.
module tb_decode_issue_rv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] issue_count;
    logic [3:0]  issue_count4;

    decode_issue_rv_if bus ();
    decode_issue_rv_if bus4 ();

    decode_issue_rv #(.COUNT_WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .issue_count (issue_count)
    );

    decode_issue_rv #(.COUNT_WIDTH(4)) dut4 (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus4),
        .issue_count (issue_count4)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [6:0]  en;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Enable vector order: {rr, ri, auipc, lui, jal, jalr, branch}
    logic [6:0] opc_tab [8] = '{7'b1100011, 7'b1100111, 7'b1101111, 7'b0110111,
                                7'b0010111, 7'b0010011, 7'b0110011, 7'b0000011};
    logic [6:0] en_tab  [8] = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000,
                                7'b0010000, 7'b0100000, 7'b1000000, 7'b0000000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every head handshake against the scoreboard front.
    exp_t       mon_e;
    logic [6:0] mon_en;
    always @(negedge clock) begin
        #2;
        mon_en = {bus.alu_register_register_enable, bus.alu_register_immediate_enable,
                  bus.alu_upper_immediate_auipc_enable, bus.alu_upper_immediate_lui_enable,
                  bus.alu_unconditional_jal_enable, bus.alu_unconditional_jalr_enable,
                  bus.alu_branch_enable};
        if (bus.out_valid) begin
            if (bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pop", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_instruction", bus.out_instruction, mon_e.instr);
                    check("out_pc", bus.out_pc, mon_e.pc);
                    check("out_rs1", bus.out_rs1, mon_e.instr[19:15]);
                    check("out_rs2", bus.out_rs2, mon_e.instr[24:20]);
                    check("enables", mon_en, mon_e.en);
                    check("out_illegal", bus.out_illegal, mon_e.ill);
                end
            end
        end else begin
            check("idle_outputs_zero",
                  |{bus.out_instruction, bus.out_pc, bus.out_rs1, bus.out_rs2, mon_en, bus.out_illegal},
                  64'd0);
        end
    end

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.flush    = 1'b0;
        bus4.out_ready = 1'b0;
        bus4.in_instruction = '0;
        bus4.in_pc    = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        sb_q.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [6:0] en, input logic ill);
        exp_t        e;
        int unsigned tries = 0;
        bit          done  = 1'b0;
        while (!done) begin
            @(negedge clock);
            bus.in_valid       = 1'b1;
            bus.in_instruction = instr;
            bus.in_pc          = pc;
            #1;
            if (bus.in_ready) begin
                e.instr = instr; e.pc = pc; e.en = en; e.ill = ill;
                sb_q.push_back(e);
                done = 1'b1;
                @(posedge clock);
                #1;
                bus.in_valid = 1'b0;
            end else if (++tries > 50) begin
                check("push_timeout", 64'd0, 64'd1);
                bus.in_valid = 1'b0;
                done = 1'b1;
            end
        end
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clock);
            #3;
            n++;
        end
        check({name, "_drain"}, 64'(sb_q.size()), 64'd0);
        @(negedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        int unsigned stall;
        int unsigned n4;
        int unsigned cyc;

        // Reset state, with in_valid asserted to show in_ready stays low.
        idle_inputs();
        bus.in_instruction = 32'h0000_0013;
        bus.in_pc          = '0;
        bus.in_valid       = 1'b1;
        bus.out_ready      = 1'b1;
        #7;
        check("rst_in_ready", bus.in_ready, 64'd0);
        check("rst_out_valid", bus.out_valid, 64'd0);
        check("rst_issue_count", issue_count, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 64'd1);
        check("post_rst_out_valid", bus.out_valid, 64'd0);

        // Single addi, one-cycle latency.
        push(32'h0050_0093, 32'h0000_0000, 7'b0100000, 1'b0);
        check("addi_latency_valid", bus.out_valid, 64'd1);
        drain("addi");
        check("addi_issue_count", issue_count, 64'd1);

        // Fill to two with the ALU stalled, then drain in order.
        do_reset();
        bus.out_ready = 1'b0;
        push(32'h1234_50B7, 32'h0000_0004, 7'b0001000, 1'b0);
        push(32'h0000_0297, 32'h0000_0008, 7'b0010000, 1'b0);
        check("full_in_ready", bus.in_ready, 64'd0);
        check("full_out_valid", bus.out_valid, 64'd1);
        @(negedge clock);
        #1;
        check("full_hold_in_ready", bus.in_ready, 64'd0);
        bus.out_ready = 1'b1;
        drain("lui_auipc");
        check("lui_auipc_issue_count", issue_count, 64'd2);

        // 100-cycle stream, one push and one pop per cycle.
        do_reset();
        bus.out_ready = 1'b1;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            bus.in_valid       = 1'b1;
            bus.in_instruction = {25'(i * 32'h0003_1F5B), opc_tab[i % 8]};
            bus.in_pc          = 32'h0000_1000 + 32'(i * 4);
            #1;
            if (!bus.in_ready) begin
                stall++;
            end else begin
                e.instr = bus.in_instruction;
                e.pc    = bus.in_pc;
                e.en    = en_tab[i % 8];
                e.ill   = (i % 8 == 7);
                sb_q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        check("stream_stalls", 64'(stall), 64'd0);
        drain("stream");
        check("stream_issue_count", issue_count, 64'd100);

        // Flush with two buffered entries while both sides try to move.
        do_reset();
        bus.out_ready = 1'b0;
        push(32'h00A0_0113, 32'h0000_0040, 7'b0100000, 1'b0);
        push(32'h0020_81B3, 32'h0000_0044, 7'b1000000, 1'b0);
        @(negedge clock);
        bus.flush          = 1'b1;
        bus.out_ready      = 1'b1;
        bus.in_valid       = 1'b1;
        bus.in_instruction = 32'h0000_0013;
        #1;
        check("flush_out_valid", bus.out_valid, 64'd0);
        check("flush_in_ready", bus.in_ready, 64'd0);
        @(negedge clock);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        sb_q.delete();
        #1;
        check("after_flush_out_valid", bus.out_valid, 64'd0);
        check("after_flush_in_ready", bus.in_ready, 64'd1);
        check("after_flush_issue_count", issue_count, 64'd0);

        // Flush while empty only blocks in_ready for that cycle.
        @(negedge clock);
        bus.flush = 1'b1;
        #1;
        check("empty_flush_in_ready", bus.in_ready, 64'd0);
        @(negedge clock);
        bus.flush = 1'b0;
        #1;
        check("empty_flush_recover_in_ready", bus.in_ready, 64'd1);
        check("empty_flush_out_valid", bus.out_valid, 64'd0);
        push(32'h00A0_0113, 32'h0000_0048, 7'b0100000, 1'b0);
        drain("post_flush");
        check("post_flush_issue_count", issue_count, 64'd1);

        // Illegal opcodes still pop and count.
        do_reset();
        bus.out_ready = 1'b1;
        push(32'hFFFF_FFFF, 32'h0000_0200, 7'b0000000, 1'b1);
        push(32'h0050_0090, 32'h0000_0204, 7'b0000000, 1'b1);
        drain("illegal");
        check("illegal_issue_count", issue_count, 64'd2);

        // Asynchronous reset between edges with one entry buffered.
        do_reset();
        bus.out_ready = 1'b1;
        push(32'h0050_0093, 32'h0000_0300, 7'b0100000, 1'b0);
        drain("pre_async");
        bus.out_ready = 1'b0;
        push(32'h1234_50B7, 32'h0000_0304, 7'b0001000, 1'b0);
        @(negedge clock);
        #3;
        check("pre_async_out_valid", bus.out_valid, 64'd1);
        check("pre_async_issue_count", issue_count, 64'd1);
        reset = 1'b1;
        sb_q.delete();
        #1;
        check("async_out_valid", bus.out_valid, 64'd0);
        check("async_in_ready", bus.in_ready, 64'd0);
        check("async_issue_count", issue_count, 64'd0);
        @(negedge clock);
        reset              = 1'b0;
        bus.in_valid       = 1'b1;
        bus.in_instruction = 32'h0000_0297;
        bus.in_pc          = 32'h0000_0308;
        #1;
        check("first_edge_in_ready", bus.in_ready, 64'd1);
        e.instr = 32'h0000_0297; e.pc = 32'h0000_0308; e.en = 7'b0010000; e.ill = 1'b0;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("post_async");
        check("post_async_issue_count", issue_count, 64'd1);

        // 4-bit counter wraps after 16 pops.
        do_reset();
        bus4.out_ready = 1'b1;
        n4  = 0;
        cyc = 0;
        while (n4 < 17 && cyc < 100) begin
            @(negedge clock);
            bus4.in_valid       = 1'b1;
            bus4.in_instruction = 32'h0000_0013;
            bus4.in_pc          = 32'(cyc * 4);
            #1;
            if (bus4.in_ready) n4++;
            cyc++;
        end
        @(posedge clock);
        #1;
        bus4.in_valid = 1'b0;
        check("wrap_pushes", 64'(n4), 64'd17);
        repeat (4) @(negedge clock);
        #1;
        check("wrap_out_valid", bus4.out_valid, 64'd0);
        check("wrap_issue_count", issue_count4, 64'd1);

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_rv.md
DECODE_ISSUE_RV -- requirements
Module: decode_issue_rv

Interface
REQ-001 Parameter COUNT_WIDTH, default 32, width of issue_count.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  fetch presents an instruction.
REQ-005 in_ready  output  1  block can accept an instruction this cycle.
REQ-006 in_instruction  input  32  raw RV32I instruction word.
REQ-007 in_pc  input  32  PC of in_instruction.
REQ-008 flush  input  1  discard all buffered instructions (taken branch/jump).
REQ-009 out_valid  output  1  head entry presented to ALU.
REQ-010 out_ready  input  1  ALU consumes head entry this cycle.
REQ-011 out_instruction  output  32  head instruction word.
REQ-012 out_pc  output  32  head PC.
REQ-013 out_rs1, out_rs2  output  5 each  head bits [19:15], [24:20] for register-file read.
REQ-014 alu_branch_enable, alu_unconditional_jalr_enable, alu_unconditional_jal_enable, alu_upper_immediate_lui_enable, alu_upper_immediate_auipc_enable, alu_register_immediate_enable, alu_register_register_enable  output  1 each  one-hot class of head.
REQ-015 out_illegal  output  1  head opcode not in supported set.
REQ-016 issue_count  output  COUNT_WIDTH  number of completed output handshakes.

Function
REQ-017 The block SHALL hold a 2-entry FIFO of {instruction, pc}; occupancy 0..2.
REQ-018 in_ready SHALL be 1 iff occupancy < 2 and flush = 0 and reset = 0.
REQ-019 Push occurs when in_valid & in_ready; pop occurs when out_valid & out_ready.
REQ-020 out_valid SHALL be 1 iff occupancy > 0 and flush = 0.
REQ-021 An instruction pushed at edge N SHALL be presented on outputs after edge N (latency 1 cycle, no combinational in->out path).
REQ-022 Push and pop in the same cycle SHALL leave occupancy unchanged and preserve order; at occupancy 2 only pop is possible.
REQ-023 Classification of head opcode [6:0]: 1100011 branch, 1100111 jalr, 1101111 jal, 0110111 lui, 0010111 auipc, 0010011 register-immediate, 0110011 register-register.
REQ-024 Exactly one enable SHALL be 1 when out_valid = 1 and opcode is supported; all enables SHALL be 0 when out_valid = 0.
REQ-025 out_illegal SHALL be 1 when out_valid = 1 and opcode matches none of REQ-023 (includes [1:0] != 11); all enables are then 0 and the entry is still popped normally.
REQ-026 When out_valid = 0, out_instruction, out_pc, out_rs1, out_rs2 SHALL be 0.
REQ-027 flush SHALL empty the FIFO at the next edge; no push or pop occurs in a flush cycle; issue_count is not incremented.
REQ-028 issue_count SHALL increment by 1 per pop and wrap from 2^COUNT_WIDTH-1 to 0.
REQ-029 flush with occupancy 0 SHALL have no effect other than blocking in_ready for that cycle.

Reset
REQ-030 On reset assertion, occupancy SHALL go to 0 and issue_count to 0 immediately, without waiting for a clock edge.
REQ-031 During reset all outputs SHALL be 0, including in_ready.
REQ-032 Reset asserted mid-operation SHALL discard buffered entries; the first edge after deassertion may accept a push.

Structure
REQ-033 Opcode constants (7 values) and the 7-bit enable-vector bit indices SHALL live in shared package rv32i_pkg.
REQ-034 Opcode classification SHALL be a combinational sub-module decode_class_rv (opcode in, 7-bit one-hot plus illegal out).
REQ-035 FIFO storage SHALL be two registered entries with read/write pointers; no latches.

Verification
REQ-036 Push 0x00500093 (addi x1,x0,5) at pc 0x0, out_ready=1 -> next cycle out_valid=1, alu_register_immediate_enable=1, out_rs1=0, issue_count=1 after pop.
REQ-037 out_ready=0, push 0x123450B7 then 0x00000297 -> occupancy 2, in_ready=0; then out_ready=1 -> lui popped first, then auipc, issue_count=2.
REQ-038 Continuous in_valid and out_ready=1 for 100 cycles -> 1 push and 1 pop per cycle, issue_count=100, order preserved.
REQ-039 Occupancy 2, flush=1 with out_ready=1 and in_valid=1 -> out_valid=0 and in_ready=0 that cycle, occupancy 0 next, issue_count unchanged.
REQ-040 Push 0xFFFFFFFF -> out_illegal=1, all enables 0, pop increments issue_count.
REQ-041 Assert reset asynchronously between edges with occupancy 1 -> out_valid drops immediately, issue_count=0; COUNT_WIDTH=4 run of 17 pops -> issue_count=1.
